iir_bank_sequencer: RTL and testbench
=====================================

// Module: iir_bank_sequencer
// PURPOSE
//  Time-multiplexes one IIR low-pass update across BINS frequency bins.
//  - Accepts one frame of BINS signed N-bit bin magnitudes via valid/ready.
//  - Updates each bin's accumulator serially: acc += (in - acc) >>> IIRCONST.
//  - Presents all filtered bins with a one-cycle out_valid pulse.
//  - Sits between the DFT bin stage and note/peak detection; replaces BINS parallel filters.
// PARAMETERS
//  N        16  width of bin input/output samples, signed
//  BINS     24  number of bins per frame (>=2)
//  IIRCONST 6   shift amount; filter gain per update = 2^-IIRCONST (1..FPF)
//  FPF      7   fractional bits held in each accumulator
// PORTS
//  clk       in   1       clock, all state on rising edge
//  rst       in   1       asynchronous, active-low reset
//  in_data   in   BINS*N  frame input; bin b at [b*N +: N], signed
//  in_valid  in   1       frame offered; producer holds data until accepted
//  in_ready  out  1       high only in IDLE with no clear pending
//  clear     in   1       one-cycle request to zero all accumulators
//  out_data  out  BINS*N  filtered bins, same packing; registered
//  out_valid out  1       one-cycle pulse when out_data refreshed
//  busy      out  1       high in LOAD/RUN/DONE
// BEHAVIOUR
//  Reset (rst=0, async): accumulators=0, out_data=0, out_valid=0, busy=0, FSM=IDLE, clear_pend=0.
//  in_ready is 1 from the first edge after release.
//  Accumulator width W=N+FPF, signed. in_ext = in <<< FPF (sign-extended).
//  delta = in_ext - acc, computed in W+1 bits. acc_next = acc + (delta >>> IIRCONST).
//  Shift is arithmetic. acc stays within the N-bit input range, so no overflow handling.
//  out = acc >>> FPF, truncated: floor toward -inf, low N bits.
//  FSM:
//   IDLE: if clear_pend, zero all accs and clear_pend; stay IDLE, in_ready=0 that cycle.
//         else if in_valid&in_ready, latch in_data into frame buffer, idx=0, go RUN.
//   RUN:  one bin per cycle. Read acc[idx], write acc_next. idx++.
//         At idx=BINS-1, go DONE.
//   DONE: copy all accs >>> FPF into out_data. out_valid=1 for this cycle only. Go IDLE.
//  Latency: accept edge -> out_valid high after BINS+1 edges. Throughput: 1 frame / (BINS+2) cycles.
//  clear:
//   - Any cycle, sets clear_pend.
//   - During RUN/DONE the current frame completes unchanged; clear takes effect in the next IDLE cycle.
//   - clear and in_valid together in IDLE: clear wins; frame stays pending (in_ready=0).
//  in_valid while busy: ignored, no loss; producer holds data.
//  out_data holds its value between DONE cycles. A clear does not zero out_data until the next DONE.
//  Reset mid-RUN: frame discarded, all state to reset values immediately.
// CONFIGURATION
//  IIR_ROUND_EN defined:
//    - delta shift rounds half-up: (delta + 2^(IIRCONST-1)) >>> IIRCONST.
//    - out rounds half-up: (acc + 2^(FPF-1)) >>> FPF, then clamped to N-bit signed max.
//  Not defined: both shifts truncate (floor). All test values below assume undefined.
// STRUCTURE
//  Shared package cchw_filter_pkg:
//   - localparam W; typedef logic signed [W-1:0] acc_t; typedef enum {IDLE,LOAD,RUN,DONE} iir_seq_state_t.
//   - LOAD is reserved; unused in this block.
//  Sub-module iir_update_unit (combinational): in, acc -> acc_next. Parameters N, IIRCONST, FPF.
//  Accumulators: BINS x W register array (flops, not RAM). idx counter $clog2(BINS) bits.
// TESTING (BINS=4, N=16, IIRCONST=6, FPF=7)
//  1. Reset -> out_data all 0, out_valid 0, in_ready 1, busy 0.
//  2. Frame {10000,10000,10000,10000} -> out_valid exactly 5 edges after accept; all bins 156.
//     Second identical frame -> all bins 310.
//  3. Frame {-10000,0,20000,-1} from zero -> {-157,0,312,-1}.
//     in_valid held high through busy -> in_ready 0 until IDLE; exactly one accept per frame.
//  4. Pulse clear in RUN cycle 2 of a 10000 frame -> out 156, then one IDLE clear cycle.
//     Next 10000 frame -> 156 (not 310).
//  5. Assert rst mid-RUN -> all outputs 0 immediately. No out_valid. Next frame of 10000 -> 156.
//  6. Nine frames of 10000 then frame of 20000 -> bin values track 1321 then 1613 (+-1 LSB).

Source files
------------

// File: rtl/cchw_filter_pkg.sv
// Shared filter-stage types: accumulator width/type and sequencer state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// W and acc_t describe the default configuration (N=16, FPF=7); modules that
// take N/FPF as parameters derive their own widths from them.
package cchw_filter_pkg;

  localparam int IIR_N   = 16;
  localparam int IIR_FPF = 7;
  localparam int W       = IIR_N + IIR_FPF;

  typedef logic signed [W-1:0] acc_t;

  // LOAD is reserved for sequencers that stage frames over several cycles.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } iir_seq_state_t;

endpackage

// File: rtl/iir_update_unit.sv
// One IIR low-pass step: acc_next = acc + ((in <<< FPF) - acc) >>> IIRCONST.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   in_bin   signed N-bit bin sample
//   acc      signed (N+FPF)-bit accumulator, FPF fractional bits
//   acc_next updated accumulator
// Build option IIR_ROUND_EN: the step shift rounds half-up instead of flooring.
module iir_update_unit #(
  parameter int N        = 16,
  parameter int IIRCONST = 6,
  parameter int FPF      = 7
) (
  input  logic signed [N-1:0]     in_bin,
  input  logic signed [N+FPF-1:0] acc,
  output logic signed [N+FPF-1:0] acc_next
);

  localparam int AW = N + FPF;
  // Two guard bits: one for the difference, one for the rounding offset.
  localparam int DW = AW + 2;

  logic signed [DW-1:0] in_ext;
  logic signed [DW-1:0] delta;
  logic signed [DW-1:0] step;

  always_comb begin
    in_ext = DW'(in_bin) <<< FPF;
    delta  = in_ext - DW'(acc);
`ifdef IIR_ROUND_EN
    step   = (delta + DW'(1 << (IIRCONST - 1))) >>> IIRCONST;
`else
    step   = delta >>> IIRCONST;
`endif
    // The result stays inside the input range, so dropping guard bits is exact.
    acc_next = AW'(DW'(acc) + step);
  end

endmodule

// File: rtl/iir_bank_sequencer.sv
// Serially applies one IIR low-pass update to each of BINS bins per input frame.
// Latency: out_valid rises BINS+1 edges after the accept edge; 1 frame per BINS+2 cycles.
// Backpressure: in_ready low while busy or a clear is pending; producer holds the frame.
//
// Ports:
//   clk, rst   clock; asynchronous active-low reset
//   in_data    BINS packed signed N-bit bins (bin b at [b*N +: N]), with in_valid/in_ready
//   clear      one-cycle request to zero all accumulators (applied in the next IDLE cycle)
//   out_data   registered filtered bins, same packing; out_valid pulses when refreshed
//   busy       high while a frame is being processed
// Build option IIR_ROUND_EN: rounding in the update step and in the output conversion.
module iir_bank_sequencer
  import cchw_filter_pkg::*;
#(
  parameter int N        = 16,
  parameter int BINS     = 24,
  parameter int IIRCONST = 6,
  parameter int FPF      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BINS*N-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic [BINS*N-1:0] out_data,
  output logic              out_valid,
  output logic              busy
);

  localparam int AW = N + FPF;
  localparam int IW = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BINS - 1);

  typedef logic signed [AW-1:0] bin_acc_t;

  iir_seq_state_t     state_q, state_d;
  logic [IW-1:0]      idx_q;
  logic [BINS*N-1:0]  frame_q;
  bin_acc_t           acc_q [BINS];
  bin_acc_t           acc_next;
  logic               clear_pend;
  logic               alive_q;     // keeps in_ready low until the first edge after reset
  logic [BINS*N-1:0]  out_c;
  logic               do_clear, do_accept, do_update, do_done;

  // A clear arriving in the same cycle as a frame must win, so it blocks
  // in_ready combinationally before clear_pend has even been registered.
  assign in_ready = (state_q == IDLE) && alive_q && !clear_pend && !clear;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    do_clear  = 1'b0;
    do_accept = 1'b0;
    do_update = 1'b0;
    do_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_pend) begin
          do_clear = 1'b1;
        end else if (in_valid && in_ready) begin
          do_accept = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        do_update = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        do_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  iir_update_unit #(
    .N        (N),
    .IIRCONST (IIRCONST),
    .FPF      (FPF)
  ) u_update (
    .in_bin   ($signed(frame_q[int'(idx_q)*N +: N])),
    .acc      (acc_q[idx_q]),
    .acc_next (acc_next)
  );

  function automatic logic [N-1:0] acc_to_out(input bin_acc_t a);
`ifdef IIR_ROUND_EN
    logic signed [AW:0] r;
    r = (AW+1)'(a) + (AW+1)'(1 << (FPF - 1));
    r = r >>> FPF;
    // Rounding up can step one past the positive input maximum.
    if (r > (AW+1)'((1 << (N - 1)) - 1)) return N'((1 << (N - 1)) - 1);
    return N'(r);
`else
    return N'(a >>> FPF);
`endif
  endfunction

  always_comb begin
    out_c = '0;
    for (int b = 0; b < BINS; b++) out_c[b*N +: N] = acc_to_out(acc_q[b]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      clear_pend <= 1'b0;
      alive_q    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      for (int b = 0; b < BINS; b++) acc_q[b] <= '0;
    end else begin
      state_q    <= state_d;
      alive_q    <= 1'b1;
      out_valid  <= do_done;
      // A clear raised in the very cycle the pending one is serviced stays pending.
      clear_pend <= clear || (clear_pend && !do_clear);
      if (do_accept) begin
        frame_q <= in_data;
        idx_q   <= '0;
      end else if (do_update) begin
        idx_q   <= idx_q + 1'b1;
      end
      if (do_clear) begin
        for (int b = 0; b < BINS; b++) acc_q[b] <= '0;
      end else if (do_update) begin
        acc_q[idx_q] <= acc_next;
      end
      if (do_done) out_data <= out_c;
    end
  end

endmodule

// File: tb/tb_iir_bank_sequencer.sv
module tb_iir_bank_sequencer;

  localparam int N        = 16;
  localparam int BINS     = 4;
  localparam int IIRCONST = 6;
  localparam int FPF      = 7;

  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic [BINS*N-1:0] in_data  = '0;
  logic              in_valid = 1'b0;
  logic              clear    = 1'b0;
  logic              in_ready;
  logic [BINS*N-1:0] out_data;
  logic              out_valid;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iir_bank_sequencer #(
    .N        (N),
    .BINS     (BINS),
    .IIRCONST (IIRCONST),
    .FPF      (FPF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  function automatic logic [63:0] pack4(input int b0, input int b1, input int b2, input int b3);
    logic [63:0] v;
    v[15:0]  = 16'(b0);
    v[31:16] = 16'(b1);
    v[47:32] = 16'(b2);
    v[63:48] = 16'(b3);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // Offers frame d, waits for the accept edge, then counts edges until out_valid.
  // clear is pulsed for one edge when the post-accept edge count equals clr_cyc.
  task automatic send_frame(input logic [63:0] d, input int clr_cyc, output int lat);
    int w;
    w = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("accept_wait", 64'(w < 20), 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      clear = (lat == clr_cyc);
      tick();
      lat++;
    end
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int accepts;
    int seen;

    // 1. Reset state.
    #12;
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    tick();
    chk("ready_after_release", 64'(in_ready), 64'd1);
    chk("busy_after_release", 64'(busy), 64'd0);

    // 2. Two constant frames: 20000/128 -> 156, then 39687/128 -> 310.
    send_frame(pack4(10000, 10000, 10000, 10000), -1, lat);
    chk("lat_frame1", 64'(lat), 64'd5);
    chk("out_frame1", out_data, pack4(156, 156, 156, 156));
    chk("busy_at_done", 64'(busy), 64'd0);
    tick();
    chk("out_valid_pulse", 64'(out_valid), 64'd0);
    chk("out_hold", out_data, pack4(156, 156, 156, 156));
    send_frame(pack4(10000, 10000, 10000, 10000), -1, lat);
    chk("lat_frame2", 64'(lat), 64'd5);
    chk("out_frame2", out_data, pack4(310, 310, 310, 310));

    // 3. Mixed signs from zero; in_valid held high through the busy window.
    do_reset();
    in_data  = pack4(-10000, 0, 20000, -1);
    in_valid = 1'b1;
    accepts  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) accepts++;
      if (i == 2) begin
        chk("hold_ready_busy", 64'(in_ready), 64'd0);
        chk("hold_busy", 64'(busy), 64'd1);
      end
      tick();
    end
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    chk("hold_accepts", 64'(accepts), 64'd1);
    chk("out_mixed", out_data, pack4(-157, 0, 312, -1));
    chk("hold_ready_idle", 64'(in_ready), 64'd1);

    // 4. Clear during RUN cycle 2: frame completes, then one IDLE clear cycle.
    do_reset();
    send_frame(pack4(10000, 10000, 10000, 10000), 1, lat);
    chk("clr_lat", 64'(lat), 64'd5);
    chk("clr_frame_out", out_data, pack4(156, 156, 156, 156));
    chk("clr_ready_pending", 64'(in_ready), 64'd0);
    tick();
    chk("clr_ready_after", 64'(in_ready), 64'd1);
    chk("clr_out_hold", out_data, pack4(156, 156, 156, 156));
    send_frame(pack4(10000, 10000, 10000, 10000), -1, lat);
    chk("clr_next_frame", out_data, pack4(156, 156, 156, 156));
    // clear together with in_valid in IDLE: clear wins, frame waits.
    clear    = 1'b1;
    in_data  = pack4(10000, 10000, 10000, 10000);
    in_valid = 1'b1;
    #1;
    chk("clr_vs_valid_ready", 64'(in_ready), 64'd0);
    tick();
    clear = 1'b0;
    #1;
    chk("clr_vs_valid_pend", 64'(in_ready), 64'd0);
    tick();
    chk("clr_vs_valid_ready2", 64'(in_ready), 64'd1);
    send_frame(pack4(10000, 10000, 10000, 10000), -1, lat);
    chk("clr_vs_valid_out", out_data, pack4(156, 156, 156, 156));

    // 5. Reset mid-RUN: frame discarded, outputs zero immediately.
    in_data  = pack4(10000, 10000, 10000, 10000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_rst_no_valid", 64'(seen), 64'd0);
    send_frame(pack4(10000, 10000, 10000, 10000), -1, lat);
    chk("mid_rst_next", out_data, pack4(156, 156, 156, 156));

    // 6. Settling: frames 2..9 of 10000, then one of 20000.
    for (int k = 2; k <= 9; k++) begin
      send_frame(pack4(10000, 10000, 10000, 10000), -1, lat);
      if (k == 3) chk("settle_k3", out_data, pack4(461, 461, 461, 461));
    end
    chk("settle_k9", out_data, pack4(1321, 1321, 1321, 1321));
    send_frame(pack4(20000, 20000, 20000, 20000), -1, lat);
    chk("step_20000", out_data, pack4(1613, 1613, 1613, 1613));
    chk("step_lat", 64'(lat), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
